// File: rtl/fu_writeback_arbiter.sv
// Writeback arbiter: per-FU completion FIFOs, round-robin grant, registered PRF/wakeup/ROB outputs.
// Define WB_BYPASS_EN to let an empty FU's incoming beat be granted straight to the output stage.
module fu_writeback_arbiter #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [FU_COUNT-1:0]                             fu_out_valid,
    output logic [FU_COUNT-1:0]                             fu_out_ready,
    input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]           fu_out_inst_id,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]           fu_out_prn_valid,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_out_prn,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][63:0]     fu_out_data,
    output logic [MAX_OPERANDS-1:0]                         prf_write_enable,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]           prf_write_prn,
    output logic [MAX_OPERANDS-1:0][63:0]                   prf_write,
    output logic [MAX_OPERANDS-1:0]                         set_prn_ready,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]           set_prn,
    output logic                                            wb_valid,
    output logic [INST_ID_BITS-1:0]                         wb_inst_id
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int FU_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                inst_id;
        logic [MAX_OPERANDS-1:0]                prn_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn;
        logic [MAX_OPERANDS-1:0][63:0]          data;
    } beat_t;

    beat_t                mem [FU_COUNT][FIFO_DEPTH];
    logic [PTR_BITS-1:0]  head [FU_COUNT];
    logic [PTR_BITS-1:0]  tail [FU_COUNT];
    logic [CNT_BITS-1:0]  count [FU_COUNT];
    logic [FU_BITS-1:0]   rr_ptr;
    logic [FU_BITS-1:0]   grant;
    logic                 grant_valid;
    logic                 grant_bypass;
    logic [FU_COUNT-1:0]  cand;
    logic [FU_COUNT-1:0]  push;
    logic [FU_COUNT-1:0]  pop;
    beat_t                in_beat [FU_COUNT];
    beat_t                sel;

    always_comb begin
        for (int unsigned f = 0; f < FU_COUNT; f++) begin
            in_beat[f]      = '{fu_out_inst_id[f], fu_out_prn_valid[f], fu_out_prn[f], fu_out_data[f]};
            fu_out_ready[f] = (count[f] != CNT_BITS'(FIFO_DEPTH));
`ifdef WB_BYPASS_EN
            cand[f]         = (count[f] != '0) || fu_out_valid[f];
`else
            cand[f]         = (count[f] != '0);
`endif
        end
    end

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int unsigned k = 0; k < FU_COUNT; k++) begin
            idx = (32'(rr_ptr) + k) % FU_COUNT;
            if (!grant_valid && cand[idx]) begin
                grant_valid = 1'b1;
                grant       = FU_BITS'(idx);
            end
        end
    end

    // A granted FU with an empty FIFO can only be the bypass case.
    always_comb begin
`ifdef WB_BYPASS_EN
        grant_bypass = grant_valid && (count[grant] == '0);
`else
        grant_bypass = 1'b0;
`endif
        sel = grant_bypass ? in_beat[grant] : mem[grant][head[grant]];
        for (int unsigned f = 0; f < FU_COUNT; f++) begin
            pop[f]  = grant_valid && !grant_bypass && (grant == FU_BITS'(f));
            push[f] = fu_out_valid[f] && fu_out_ready[f] && !(grant_bypass && (grant == FU_BITS'(f)));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned f = 0; f < FU_COUNT; f++) begin
            if (push[f]) begin
                mem[f][tail[f]] <= in_beat[f];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int unsigned f = 0; f < FU_COUNT; f++) begin
                head[f]  <= '0;
                tail[f]  <= '0;
                count[f] <= '0;
            end
        end else begin
            if (grant_valid) begin
                rr_ptr <= (grant == FU_BITS'(FU_COUNT - 1)) ? '0 : grant + 1'b1;
            end
            for (int unsigned f = 0; f < FU_COUNT; f++) begin
                if (push[f]) tail[f] <= tail[f] + 1'b1;
                if (pop[f])  head[f] <= head[f] + 1'b1;
                if (push[f] && !pop[f]) begin
                    count[f] <= count[f] + 1'b1;
                end else if (pop[f] && !push[f]) begin
                    count[f] <= count[f] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid         <= 1'b0;
            wb_inst_id       <= '0;
            prf_write_enable <= '0;
            prf_write_prn    <= '0;
            prf_write        <= '0;
        end else if (grant_valid) begin
            wb_valid         <= 1'b1;
            wb_inst_id       <= sel.inst_id;
            prf_write_enable <= sel.prn_valid;
            prf_write_prn    <= sel.prn;
            prf_write        <= sel.data;
        end else begin
            wb_valid         <= 1'b0;
            prf_write_enable <= '0;
        end
    end

    assign set_prn_ready = prf_write_enable;
    assign set_prn       = prf_write_prn;

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Bench for fu_writeback_arbiter: queue-based reference model, directed vector table, corner sequences, random run.
module tb_fu_writeback_arbiter;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int M  = 3;
    localparam int IB = 6;
    localparam int PB = 6;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [N-1:0]                 fu_out_valid;
    logic [N-1:0]                 fu_out_ready;
    logic [N-1:0][IB-1:0]         fu_out_inst_id;
    logic [N-1:0][M-1:0]          fu_out_prn_valid;
    logic [N-1:0][M-1:0][PB-1:0]  fu_out_prn;
    logic [N-1:0][M-1:0][63:0]    fu_out_data;
    logic [M-1:0]                 prf_write_enable;
    logic [M-1:0][PB-1:0]         prf_write_prn;
    logic [M-1:0][63:0]           prf_write;
    logic [M-1:0]                 set_prn_ready;
    logic [M-1:0][PB-1:0]         set_prn;
    logic                         wb_valid;
    logic [IB-1:0]                wb_inst_id;

    fu_writeback_arbiter #(
        .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(M), .FU_COUNT(N), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_out_valid(fu_out_valid), .fu_out_ready(fu_out_ready),
        .fu_out_inst_id(fu_out_inst_id), .fu_out_prn_valid(fu_out_prn_valid),
        .fu_out_prn(fu_out_prn), .fu_out_data(fu_out_data),
        .prf_write_enable(prf_write_enable), .prf_write_prn(prf_write_prn),
        .prf_write(prf_write), .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .wb_valid(wb_valid), .wb_inst_id(wb_inst_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IB-1:0]         id;
        logic [M-1:0]          pv;
        logic [M-1:0][PB-1:0]  prn;
        logic [M-1:0][63:0]    data;
    } beat_t;

    typedef struct {
        int                    fu;
        logic [IB-1:0]         id;
        logic [M-1:0]          pv;
        logic [M-1:0][PB-1:0]  prn;
        logic [M-1:0][63:0]    data;
        logic [IB-1:0]         e_id;
        logic [M-1:0]          e_en;
        logic [M-1:0][PB-1:0]  e_prn;
        logic [M-1:0][63:0]    e_data;
    } vec_t;

    // Reference model: one queue per FU, a round-robin start index and the expected output registers.
    beat_t                 q[N][$];
    int                    rr;
    logic                  m_v;
    logic [IB-1:0]         m_id;
    logic [M-1:0]          m_en;
    logic [M-1:0][PB-1:0]  m_prn;
    logic [M-1:0][63:0]    m_data;
    bit                    inited = 1'b0;
    logic [N-1:0]          acc;
    int                    checks = 0;
    int                    errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t in_beat(input int f);
        return {fu_out_inst_id[f], fu_out_prn_valid[f], fu_out_prn[f], fu_out_data[f]};
    endfunction

    task automatic step();
        int    g;
        bit    byp;
        bit    rdy[N];
        beat_t e;
        for (int f = 0; f < N; f++) begin
            rdy[f] = (q[f].size() != D);
            if (inited) chk("fu_out_ready", 64'(fu_out_ready[f]), 64'(rdy[f]));
        end
        acc = '0;
        g   = -1;
        byp = 1'b0;
        if (rst) begin
            for (int f = 0; f < N; f++) q[f].delete();
            rr = 0; m_v = 1'b0; m_id = '0; m_en = '0; m_prn = '0; m_data = '0;
            inited = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int f;
                f = (rr + k) % N;
                if (g < 0 && (q[f].size() != 0 || (BYP && fu_out_valid[f]))) g = f;
            end
            if (g >= 0) begin
                if (q[g].size() != 0) begin
                    e = q[g].pop_front();
                end else begin
                    e = in_beat(g);
                    byp = 1'b1;
                    acc[g] = 1'b1;
                end
                m_v = 1'b1; m_id = e.id; m_en = e.pv; m_prn = e.prn; m_data = e.data;
                rr = (g + 1) % N;
            end else begin
                m_v = 1'b0; m_en = '0;
            end
            for (int f = 0; f < N; f++) begin
                if (fu_out_valid[f] && rdy[f] && !(byp && g == f)) begin
                    q[f].push_back(in_beat(f));
                    acc[f] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("wb_valid", 64'(wb_valid), 64'(m_v));
        chk("wb_inst_id", 64'(wb_inst_id), 64'(m_id));
        chk("prf_write_enable", 64'(prf_write_enable), 64'(m_en));
        chk("set_prn_ready", 64'(set_prn_ready), 64'(m_en));
        for (int i = 0; i < M; i++) begin
            chk("prf_write_prn", 64'(prf_write_prn[i]), 64'(m_prn[i]));
            chk("set_prn", 64'(set_prn[i]), 64'(m_prn[i]));
            chk("prf_write", prf_write[i], m_data[i]);
        end
    endtask

    task automatic do_reset(input int cycles);
        fu_out_valid = '0;
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) step();
        rst = 1'b0;
    endtask

    vec_t tv[4];
    int   n[N];
    int   got;
    int   exp2;
    bit   saw_bp;

    initial begin
        fu_out_valid = '0; fu_out_inst_id = '0; fu_out_prn_valid = '0;
        fu_out_prn = '0; fu_out_data = '0;

        tv[0] = '{1, 6'd5, 3'b001, {6'd0, 6'd0, 6'd12}, {64'd0, 64'd0, 64'hDEAD},
                  6'd5, 3'b001, {6'd0, 6'd0, 6'd12}, {64'd0, 64'd0, 64'hDEAD}};
        tv[1] = '{0, 6'd9, 3'b000, {6'd5, 6'd4, 6'd3}, {64'h3, 64'h2, 64'h1},
                  6'd9, 3'b000, {6'd5, 6'd4, 6'd3}, {64'h3, 64'h2, 64'h1}};
        tv[2] = '{3, 6'd63, 3'b111, {6'd3, 6'd2, 6'd1}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001},
                  6'd63, 3'b111, {6'd3, 6'd2, 6'd1}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001}};
        tv[3] = '{2, 6'd0, 3'b110, {6'd63, 6'd7, 6'd0}, {64'hAAAA, 64'h5555, 64'h0},
                  6'd0, 3'b110, {6'd63, 6'd7, 6'd0}, {64'hAAAA, 64'h5555, 64'h0}};

        do_reset(2);
        chk("reset_ready", 64'(fu_out_ready), 64'({N{1'b1}}));
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);

        // Directed single-beat vectors
        for (int v = 0; v < 4; v++) begin
            do_reset(2);
            fu_out_valid[tv[v].fu]     = 1'b1;
            fu_out_inst_id[tv[v].fu]   = tv[v].id;
            fu_out_prn_valid[tv[v].fu] = tv[v].pv;
            fu_out_prn[tv[v].fu]       = tv[v].prn;
            fu_out_data[tv[v].fu]      = tv[v].data;
            step();
            fu_out_valid = '0;
`ifndef WB_BYPASS_EN
            chk("tv_early_wb_valid", 64'(wb_valid), 64'd0);
            step();
`endif
            chk("tv_wb_valid", 64'(wb_valid), 64'd1);
            chk("tv_wb_inst_id", 64'(wb_inst_id), 64'(tv[v].e_id));
            chk("tv_prf_write_enable", 64'(prf_write_enable), 64'(tv[v].e_en));
            chk("tv_set_prn_ready", 64'(set_prn_ready), 64'(tv[v].e_en));
            for (int i = 0; i < M; i++) begin
                chk("tv_set_prn", 64'(set_prn[i]), 64'(tv[v].e_prn[i]));
                chk("tv_prf_write", prf_write[i], tv[v].e_data[i]);
            end
            step();
            chk("tv_single_completion", 64'(wb_valid), 64'd0);
        end

        // Fairness: all FUs streaming, ids encode {fu, sequence}
        do_reset(1);
        for (int f = 0; f < N; f++) begin
            n[f] = 0;
            fu_out_inst_id[f] = IB'(f * 16);
            fu_out_prn_valid[f] = 3'(f + 1);
        end
        fu_out_valid = '1;
        got = 0;
        for (int c = 0; c < 6 && !wb_valid; c++) begin
            step();
            for (int f = 0; f < N; f++) if (acc[f]) begin n[f]++; fu_out_inst_id[f] = IB'(f * 16 + n[f] % 16); end
        end
        chk("fair_start", 64'(wb_valid), 64'd1);
        for (int k = 0; k < 12; k++) begin
            chk("fair_valid", 64'(wb_valid), 64'd1);
            chk("fair_id", 64'(wb_inst_id), 64'((k % 4) * 16 + k / 4));
            step();
            for (int f = 0; f < N; f++) if (acc[f]) begin n[f]++; fu_out_inst_id[f] = IB'(f * 16 + n[f] % 16); end
        end
        fu_out_valid = '0;
        for (int c = 0; c < 10; c++) step();

        // Backpressure on FU2 while FU0/FU1 stay busy
        do_reset(1);
        for (int f = 0; f < N; f++) begin n[f] = 0; fu_out_inst_id[f] = IB'(f * 16); end
        fu_out_valid = 4'b0111;
        exp2 = 0; saw_bp = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 30) fu_out_valid = '0;
            step();
            if (!fu_out_ready[2]) saw_bp = 1'b1;
            if (wb_valid && wb_inst_id[5:4] == 2'd2) begin
                chk("bp_order", 64'(wb_inst_id[3:0]), 64'(exp2 % 16));
                exp2++;
            end
            for (int f = 0; f < N; f++) if (acc[f]) begin n[f]++; fu_out_inst_id[f] = IB'(f * 16 + n[f] % 16); end
        end
        chk("bp_seen", 64'(saw_bp), 64'd1);
        chk("bp_count", 64'(exp2), 64'(n[2]));

        // Wrap: 10 back-to-back beats on FU3
        do_reset(1);
        n[3] = 0; got = 0;
        fu_out_inst_id[3] = '0;
        fu_out_valid = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            if (acc[3]) begin
                n[3]++;
                fu_out_inst_id[3] = IB'(n[3]);
                if (n[3] == 10) fu_out_valid = '0;
            end
            if (got > 0 && got < 10) chk("wrap_rate", 64'(wb_valid), 64'd1);
            if (wb_valid) begin
                chk("wrap_id", 64'(wb_inst_id), 64'(got));
                got++;
            end
        end
        chk("wrap_count", 64'(got), 64'd10);

        // Reset mid-operation discards buffered beats
        do_reset(1);
        fu_out_inst_id[0] = 6'd40; fu_out_inst_id[1] = 6'd41; fu_out_inst_id[2] = 6'd42;
        fu_out_valid = 4'b0111;
        step();
        fu_out_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_mid_enable", 64'(prf_write_enable), 64'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rst_mid_flush", 64'(wb_valid), 64'd0);
        end

        // Randomized traffic with occasional reset
        do_reset(1);
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int f = 0; f < N; f++) begin
                fu_out_valid[f]     = ($urandom_range(0, 9) < 6);
                fu_out_inst_id[f]   = IB'($urandom);
                fu_out_prn_valid[f] = M'($urandom);
                for (int i = 0; i < M; i++) begin
                    fu_out_prn[f][i]  = PB'($urandom);
                    fu_out_data[f][i] = {$urandom, $urandom};
                end
            end
            step();
        end
        rst = 1'b0;
        fu_out_valid = '0;
        for (int c = 0; c < 12; c++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
